// File: rtl/selector_cuadro_if.sv
// Button/board inputs and cursor/selection outputs of the selector_cuadro input stage.
// master: the side driving buttons and board state; slave: selector_cuadro itself.
interface selector_cuadro_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic       habilitado;
  logic [8:0] ocupado;
  logic [8:0] cuadro;
  logic [8:0] cursor;
  logic       rechazado;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_select, habilitado, ocupado,
    input  cuadro, cursor, rechazado
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_select, habilitado, ocupado,
    output cuadro, cursor, rechazado
  );
endinterface

// File: rtl/selector_cuadro.sv
// Tic-tac-toe input stage: synchronises and debounces five buttons, moves a 3x3 cursor and
// emits one-hot square selections. Define CURSOR_WRAP_EN to wrap the cursor at the board edges.
module selector_cuadro #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic               clk_100MHz,
  input logic               reset_n,
  selector_cuadro_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDown  = 1;
  localparam int unsigned BtnLeft  = 2;
  localparam int unsigned BtnRight = 3;
  localparam int unsigned BtnSel   = 4;

  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync2_q;
  logic [4:0] deb_q, deb_d, deb_prev_q;
  logic [4:0] ev_q, ev_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  logic [1:0] row_q, row_d, col_q, col_d;
  logic [8:0] cursor_q, cursor_d;
  logic [8:0] cuadro_q, cuadro_d;
  logic       rech_q, rech_d;
  logic [3:0] sel_idx, nxt_idx;

  assign btn_raw = {bus.btn_select, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // Counter runs only while the synced level disagrees with the accepted level.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    ev_d = deb_q & ~deb_prev_q;
  end

  function automatic logic [1:0] pos_dec(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
`else
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
`endif
  endfunction

  function automatic logic [1:0] pos_inc(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
`else
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
`endif
  endfunction

  assign sel_idx = 4'(row_q) * 4'd3 + 4'(col_q);
  assign nxt_idx = 4'(row_d) * 4'd3 + 4'(col_d);

  // Select is judged on the pre-move cursor; at most one direction event is applied.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    cuadro_d = '0;
    rech_d   = 1'b0;
    if (bus.habilitado) begin
      if (ev_q[BtnSel]) begin
        if (bus.ocupado[sel_idx]) begin
          rech_d = 1'b1;
        end else begin
          cuadro_d = 9'd1 << sel_idx;
        end
      end
      if (ev_q[BtnUp]) begin
        row_d = pos_dec(row_q);
      end else if (ev_q[BtnDown]) begin
        row_d = pos_inc(row_q);
      end else if (ev_q[BtnLeft]) begin
        col_d = pos_dec(col_q);
      end else if (ev_q[BtnRight]) begin
        col_d = pos_inc(col_q);
      end
    end
    cursor_d = 9'd1 << nxt_idx;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      ev_q       <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
      row_q    <= 2'd1;
      col_q    <= 2'd1;
      cursor_q <= 9'b000010000;
      cuadro_q <= '0;
      rech_q   <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      ev_q       <= ev_d;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      row_q    <= row_d;
      col_q    <= col_d;
      cursor_q <= cursor_d;
      cuadro_q <= cuadro_d;
      rech_q   <= rech_d;
    end
  end

  assign bus.cursor    = cursor_q;
  assign bus.cuadro    = cuadro_q;
  assign bus.rechazado = rech_q;

endmodule
